// File: rtl/ai_pkg.sv
// Shared constants for the layer scheduler.
//   DEF_INST_W  - default width of one layer instruction word
//   MAX_LAYERS  - largest layer count the scheduler can sequence
//   LAYER_AW    - width of a layer index / table address
//   S_*         - scheduler FSM state encoding
//   sat_inc32   - saturating 32-bit increment
package ai_pkg;

    localparam int DEF_INST_W = 36;
    localparam int MAX_LAYERS = 8;
    localparam int LAYER_AW   = $clog2(MAX_LAYERS);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_PIC  = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Instruction stream from the layer scheduler to the DMA engine.
//   inst_m_data  - instruction word for the current layer
//   inst_m_valid - instruction valid
//   inst_m_ready - DMA accepts the instruction
// master: scheduler side; slave: DMA side.
interface layer_sched_if
    import ai_pkg::*;
#(
    parameter int INST_W = DEF_INST_W
) ();

    logic [INST_W-1:0] inst_m_data;
    logic              inst_m_valid;
    logic              inst_m_ready;

    modport master (output inst_m_data, output inst_m_valid, input inst_m_ready);
    modport slave  (input inst_m_data, input inst_m_valid, output inst_m_ready);

endinterface

// File: rtl/inst_table.sv
// Per-layer instruction register file: NUM_LAYERS x INST_W, one write port,
// one asynchronous read port, cleared to zero on reset.
//   clk, rst_n    - clock, async active-low reset
//   we/waddr/wdata - write port (addresses >= NUM_LAYERS are dropped)
//   raddr/rdata    - async read port (out-of-range reads return zero)
module inst_table
    import ai_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int INST_W     = DEF_INST_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [LAYER_AW-1:0] waddr,
    input  logic [INST_W-1:0]   wdata,
    input  logic [LAYER_AW-1:0] raddr,
    output logic [INST_W-1:0]   rdata
);

    logic [INST_W-1:0] mem [NUM_LAYERS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < NUM_LAYERS)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < NUM_LAYERS) ? mem[raddr] : '0;

endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: on start, waits for the input picture, then issues one
// instruction per layer to the DMA and waits for that layer to complete,
// NUM_LAYERS times, then pulses done.
//   clk, rst_n                  - clock, async active-low reset
//   cfg_we/cfg_addr/cfg_data    - instruction table write (ignored while busy)
//   start, pic_ready            - inference start pulse, picture loaded level
//   inst_m                      - instruction stream (master modport)
//   layer_done                  - current layer finished pulse
//   busy, done, cur_layer, err  - status; err is sticky until the next start
//   perf_cycles                 - busy cycles of the last inference
// Build option: LAYER_SCHED_PERF_EN enables the cycle counter; otherwise
// perf_cycles is tied to zero.
//
// state       | meaning
// S_IDLE      | waiting for start
// S_WAIT_PIC  | started, waiting for pic_ready
// S_ISSUE     | instruction valid, waiting for DMA ready
// S_WAIT_DONE | instruction accepted, waiting for layer_done
// S_FINISH    | one-cycle done pulse, back to idle
module layer_sched
    import ai_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int INST_W     = DEF_INST_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [LAYER_AW-1:0] cfg_addr,
    input  logic [INST_W-1:0]   cfg_data,
    input  logic                start,
    input  logic                pic_ready,
    layer_sched_if.master       inst_m,
    input  logic                layer_done,
    output logic                busy,
    output logic                done,
    output logic [LAYER_AW-1:0] cur_layer,
    output logic                err,
    output logic [31:0]         perf_cycles
);

    logic [2:0]          state;
    logic [INST_W-1:0]   data_q;
    logic                valid_q;
    logic [INST_W-1:0]   rd_data;
    logic [LAYER_AW-1:0] rd_addr;
    logic                start_acc;
    logic                last_layer;
    logic                tbl_we;
    logic                err_set;

    assign start_acc  = start && (state == S_IDLE);
    assign last_layer = (cur_layer == LAYER_AW'(NUM_LAYERS - 1));
    assign tbl_we     = cfg_we && !busy;
    assign err_set    = (layer_done && (state inside {S_IDLE, S_WAIT_PIC, S_ISSUE}))
                      || (busy && (start || cfg_we));

    // In WAIT_DONE the table is already addressed at the next layer so the
    // instruction can be registered on the same edge as layer_done.
    assign rd_addr = (state == S_WAIT_DONE) ? cur_layer + LAYER_AW'(1) : cur_layer;

    inst_table #(
        .NUM_LAYERS (NUM_LAYERS),
        .INST_W     (INST_W)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_layer <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_WAIT_PIC;
                        busy      <= 1'b1;
                        cur_layer <= '0;
                    end
                end
                S_WAIT_PIC: begin
                    if (pic_ready) begin
                        state   <= S_ISSUE;
                        valid_q <= 1'b1;
                        data_q  <= rd_data;
                    end
                end
                S_ISSUE: begin
                    if (inst_m.inst_m_ready) begin
                        state   <= S_WAIT_DONE;
                        valid_q <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (layer_done) begin
                        if (last_layer) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            cur_layer <= rd_addr;
                            valid_q   <= 1'b1;
                            data_q    <= rd_data;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_set || (err && !start_acc);
        end
    end

    assign inst_m.inst_m_data  = data_q;
    assign inst_m.inst_m_valid = valid_q;

`ifdef LAYER_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_q;

    // The FINISH cycle is itself a busy cycle, so the snapshot takes the
    // incremented value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
            perf_q   <= '0;
        end else begin
            if (start_acc) begin
                perf_cnt <= '0;
            end else if (busy) begin
                perf_cnt <= sat_inc32(perf_cnt);
            end
            if (state == S_FINISH) begin
                perf_q <= sat_inc32(perf_cnt);
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_sched.sv
// Self-checking bench for layer_sched: randomized table contents, DMA
// back-pressure and layer latencies, checked against a table model.
module tb_layer_sched;

    localparam int NL = 5;
    localparam int IW = 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [IW-1:0] cfg_data = '0;
    logic          start = 1'b0;
    logic          pic_ready = 1'b0;
    logic          layer_done = 1'b0;
    logic          busy;
    logic          done;
    logic [2:0]    cur_layer;
    logic          err;
    logic [31:0]   perf_cycles;

    layer_sched_if #(.INST_W(IW)) sif ();

    layer_sched #(.NUM_LAYERS(NL), .INST_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start       (start),
        .pic_ready   (pic_ready),
        .inst_m      (sif),
        .layer_done  (layer_done),
        .busy        (busy),
        .done        (done),
        .cur_layer   (cur_layer),
        .err         (err),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: what the instruction table should hold
    logic [IW-1:0] tbl [NL];

    logic [IW-1:0] obs_data [$];
    bit            obs_done_seen;
    logic          obs_busy_after;
    logic          obs_err_start;
    int            obs_busy_cycles;
    int            obs_done_pulses;

    int mon_done_cnt = 0;
    int mon_busy_cnt = 0;
    always @(negedge clk) begin
        if (done === 1'b1) mon_done_cnt <= mon_done_cnt + 1;
        if (busy === 1'b1) mon_busy_cnt <= mon_busy_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input logic [2:0] a, input logic [IW-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (int'(a) < NL) tbl[a] = d;
    endtask

    task automatic program_random();
        for (int i = 0; i < NL; i++) begin
            cfg_write(3'(i), {4'($urandom), 32'($urandom)});
        end
    endtask

    // Acts as the DMA and the compute engine for n layers.
    task automatic serve_layers(input int n, input int rdy_pct, input int gap_lo,
                                input int gap_hi, input bit last_done);
        for (int l = 0; l < n; l++) begin
            int guard;
            int gap;
            bit xfer;
            bit stalled;
            logic [IW-1:0] held;
            guard = 0; xfer = 0; stalled = 0; held = '0;
            while (!xfer && guard < 200) begin
                if (stalled) begin
                    n_checks++;
                    if (sif.inst_m_valid !== 1'b1 || sif.inst_m_data !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                                 sif.inst_m_valid, sif.inst_m_data, held);
                    end
                end
                if (sif.inst_m_valid === 1'b1 && int'($urandom_range(99)) < rdy_pct) begin
                    sif.inst_m_ready = 1'b1;
                    obs_data.push_back(sif.inst_m_data);
                    xfer = 1;
                end else begin
                    sif.inst_m_ready = 1'b0;
                    stalled = (sif.inst_m_valid === 1'b1);
                    held = sif.inst_m_data;
                end
                @(negedge clk);
                guard++;
            end
            sif.inst_m_ready = 1'b0;
            if (!xfer) begin
                n_checks++; n_fail++;
                $display("FAIL issue_timeout: layer %0d got no valid, required valid within 200 cycles", l);
                return;
            end
            if (l < n - 1 || last_done) begin
                gap = $urandom_range(gap_hi, gap_lo);
                repeat (gap - 1) @(negedge clk);
                layer_done = 1'b1;
                @(negedge clk);
                layer_done = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0; obs_done_seen = 0; obs_busy_after = 1'bx;
        while (guard < 40) begin
            if (done === 1'b1) begin
                obs_done_seen = 1;
                break;
            end
            @(negedge clk);
            guard++;
        end
        if (obs_done_seen) begin
            @(negedge clk);
            obs_busy_after = busy;
        end
    endtask

    task automatic run_inf(input int rdy_pct, input int gap_lo, input int gap_hi);
        int b0, d0;
        b0 = mon_busy_cnt; d0 = mon_done_cnt;
        obs_data.delete();
        @(negedge clk);
        start = 1'b1; pic_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        obs_err_start = err;
        serve_layers(NL, rdy_pct, gap_lo, gap_hi, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        obs_busy_cycles = mon_busy_cnt - b0;
        obs_done_pulses = mon_done_cnt - d0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sif.inst_m_valid !== 1'b0 || sif.inst_m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_stream: valid=%b data=%h, required 0/0", sif.inst_m_valid, sif.inst_m_data);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b err=%b, required 0/0/0", busy, done, err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NL; i++) tbl[i] = '0;
        @(negedge clk);
        n_checks++;
        if (cur_layer !== 3'd0 || perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_layer_perf: cur_layer=%0d perf=%0d, required 0/0", cur_layer, perf_cycles);
        end
    endtask

    task automatic test_basic();
        logic [IW-1:0] base;
        base = 36'h1_0000_0000;
        for (int i = 0; i < NL; i++) cfg_write(3'(i), base + IW'(i));
        run_inf(100, 10, 10);
        n_checks++;
        if (obs_data.size() != NL) begin
            n_fail++;
            $display("FAIL basic_count: got %0d transfers, required %0d", obs_data.size(), NL);
        end
        for (int i = 0; i < obs_data.size() && i < NL; i++) begin
            n_checks++;
            if (obs_data[i] !== tbl[i]) begin
                n_fail++;
                $display("FAIL basic_inst[%0d]: got %h, required %h", i, obs_data[i], tbl[i]);
            end
        end
        n_checks++;
        if (obs_done_pulses != 1 || obs_busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done pulses=%0d busy_after=%b, required 1/0", obs_done_pulses, obs_busy_after);
        end
        n_checks++;
`ifdef LAYER_SCHED_PERF_EN
        if (perf_cycles !== 32'(obs_busy_cycles)) begin
`else
        if (perf_cycles !== 32'd0) begin
`endif
            n_fail++;
            $display("FAIL basic_perf: perf_cycles=%0d, measured busy cycles=%0d", perf_cycles, obs_busy_cycles);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        program_random();
        obs_data.delete();
        @(negedge clk);
        start = 1'b1; pic_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (sif.inst_m_valid !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (sif.inst_m_valid !== 1'b1 || sif.inst_m_data !== tbl[0]) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h, required 1 %h", k, sif.inst_m_valid, sif.inst_m_data, tbl[0]);
            end
            @(negedge clk);
        end
        sif.inst_m_ready = 1'b1;
        obs_data.push_back(sif.inst_m_data);
        @(negedge clk);
        sif.inst_m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (sif.inst_m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_single: valid=%b after accept, required 0", sif.inst_m_valid);
            end
            @(negedge clk);
        end
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        serve_layers(NL - 1, 40, 1, 5, 1'b1);
        wait_done();
        n_checks++;
        if (obs_data.size() != NL || !obs_done_seen) begin
            n_fail++;
            $display("FAIL bp_count: transfers=%0d done_seen=%0d, required %0d/1", obs_data.size(), obs_done_seen, NL);
        end
        for (int i = 0; i < obs_data.size() && i < NL; i++) begin
            n_checks++;
            if (obs_data[i] !== tbl[i]) begin
                n_fail++;
                $display("FAIL bp_inst[%0d]: got %h, required %h", i, obs_data[i], tbl[i]);
            end
        end
    endtask

    task automatic test_pic_wait();
        program_random();
        obs_data.delete();
        @(negedge clk);
        start = 1'b1; pic_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (sif.inst_m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pic_wait[%0d]: valid=%b before pic_ready, required 0", k, sif.inst_m_valid);
            end
            @(negedge clk);
        end
        pic_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sif.inst_m_valid !== 1'b1 || sif.inst_m_data !== tbl[0]) begin
            n_fail++;
            $display("FAIL pic_issue: valid=%b data=%h one cycle after pic_ready, required 1 %h",
                     sif.inst_m_valid, sif.inst_m_data, tbl[0]);
        end
        serve_layers(NL, 100, 1, 3, 1'b1);
        wait_done();
        n_checks++;
        if (obs_data.size() != NL || !obs_done_seen) begin
            n_fail++;
            $display("FAIL pic_count: transfers=%0d done_seen=%0d, required %0d/1", obs_data.size(), obs_done_seen, NL);
        end
    endtask

    task automatic test_errors();
        int d0;
        program_random();
        @(negedge clk);
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_idle_done: err=%b, required 1", err);
        end
        d0 = mon_done_cnt;
        obs_data.delete();
        start = 1'b1; pic_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear_on_start: err=%b, required 0", err);
        end
        start = 1'b1; pic_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_start_busy: err=%b, required 1", err);
        end
        serve_layers(NL, 70, 1, 4, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_data.size() != NL || (mon_done_cnt - d0) != 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_seq: transfers=%0d done=%0d err=%b, required %0d/1/1",
                     obs_data.size(), mon_done_cnt - d0, err, NL);
        end
        for (int i = 0; i < obs_data.size() && i < NL; i++) begin
            n_checks++;
            if (obs_data[i] !== tbl[i]) begin
                n_fail++;
                $display("FAIL err_inst[%0d]: got %h, required %h", i, obs_data[i], tbl[i]);
            end
        end
        run_inf(100, 1, 2);
        n_checks++;
        if (obs_err_start !== 1'b0 || obs_done_pulses != 1) begin
            n_fail++;
            $display("FAIL err_next_start: err=%b done=%0d, required 0/1", obs_err_start, obs_done_pulses);
        end
    endtask

    task automatic test_cfg_rules();
        logic [IW-1:0] nw;
        program_random();
        cfg_write(3'd6, {4'($urandom), 32'($urandom)});
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_oob_err: err=%b, required 0", err);
        end
        obs_data.delete();
        @(negedge clk);
        start = 1'b1; pic_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = ~tbl[1];
        @(negedge clk);
        cfg_we = 1'b0; pic_ready = 1'b1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_busy_err: err=%b, required 1", err);
        end
        serve_layers(NL, 80, 1, 3, 1'b1);
        wait_done();
        for (int i = 0; i < obs_data.size() && i < NL; i++) begin
            n_checks++;
            if (obs_data[i] !== tbl[i]) begin
                n_fail++;
                $display("FAIL cfg_busy_inst[%0d]: got %h, required %h", i, obs_data[i], tbl[i]);
            end
        end
        // start and table write to layer 0 on the same cycle
        nw = {4'($urandom), 32'($urandom)};
        obs_data.delete();
        @(negedge clk);
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = nw; pic_ready = 1'b1;
        tbl[0] = nw;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_start_same_err: err=%b, required 0", err);
        end
        serve_layers(NL, 100, 1, 2, 1'b1);
        wait_done();
        n_checks++;
        if (obs_data.size() != NL || obs_data[0] !== nw) begin
            n_fail++;
            $display("FAIL cfg_start_same_inst0: transfers=%0d got %h, required %0d %h",
                     obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : '0, NL, nw);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int nw;
            nw = $urandom_range(4, 1);
            for (int w = 0; w < nw; w++) cfg_write(3'($urandom_range(7)), {4'($urandom), 32'($urandom)});
            run_inf($urandom_range(100, 20), 1, $urandom_range(6, 1));
            n_checks++;
            if (obs_data.size() != NL || obs_done_pulses != 1 || obs_busy_after !== 1'b0 || obs_err_start !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_status: transfers=%0d done=%0d busy_after=%b err=%b, required %0d/1/0/0",
                         it, obs_data.size(), obs_done_pulses, obs_busy_after, obs_err_start, NL);
            end
            for (int i = 0; i < obs_data.size() && i < NL; i++) begin
                n_checks++;
                if (obs_data[i] !== tbl[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_inst[%0d]: got %h, required %h", it, i, obs_data[i], tbl[i]);
                end
            end
            n_checks++;
`ifdef LAYER_SCHED_PERF_EN
            if (perf_cycles !== 32'(obs_busy_cycles)) begin
`else
            if (perf_cycles !== 32'd0) begin
`endif
                n_fail++;
                $display("FAIL rand%0d_perf: perf_cycles=%0d, measured busy cycles=%0d", it, perf_cycles, obs_busy_cycles);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        program_random();
        d0 = mon_done_cnt;
        obs_data.delete();
        @(negedge clk);
        start = 1'b1; pic_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve_layers(3, 100, 2, 4, 1'b0);
        n_checks++;
        if (cur_layer !== 3'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: cur_layer=%0d busy=%b, required 2/1", cur_layer, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (sif.inst_m_valid !== 1'b0 || sif.inst_m_data !== '0 || busy !== 1'b0 || done !== 1'b0
            || cur_layer !== 3'd0 || err !== 1'b0 || perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: valid=%b data=%h busy=%b done=%b layer=%0d err=%b perf=%0d, required all 0",
                     sif.inst_m_valid, sif.inst_m_data, busy, done, cur_layer, err, perf_cycles);
        end
        layer_done = 1'b1;
        repeat (3) @(negedge clk);
        layer_done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < NL; i++) tbl[i] = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ((mon_done_cnt - d0) != 0 || sif.inst_m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: done pulses=%0d valid=%b, required 0/0", mon_done_cnt - d0, sif.inst_m_valid);
        end
        run_inf(100, 1, 3);
        for (int i = 0; i < obs_data.size() && i < NL; i++) begin
            n_checks++;
            if (obs_data[i] !== tbl[i]) begin
                n_fail++;
                $display("FAIL rst_table_zero[%0d]: got %h, required %h", i, obs_data[i], tbl[i]);
            end
        end
        n_checks++;
        if (obs_data.size() != NL || obs_done_pulses != 1) begin
            n_fail++;
            $display("FAIL rst_rerun: transfers=%0d done=%0d, required %0d/1", obs_data.size(), obs_done_pulses, NL);
        end
    endtask

    initial begin
        sif.inst_m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_pic_wait();
        test_errors();
        test_cfg_rules();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
